// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: shared op codes and FSM state encoding for the HI/LO multiply/divide unit
package mult_div_unit_pkg;
  localparam int MD_MULT  = 0;
  localparam int MD_MULTU = 1;
  localparam int MD_DIV   = 2;
  localparam int MD_DIVU  = 3;
  localparam int MD_MADD  = 4;
  localparam int MD_MADDU = 5;
  localparam int MD_MSUB  = 6;
  localparam int MD_MSUBU = 7;
  localparam int MD_MTHI  = 8;
  localparam int MD_MTLO  = 9;
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request/result bundle; master drives iStart/iOp/iA/iB, slave drives oBusy/oDone/oDivZero/oHI/oLO
interface mult_div_unit_if #(
  parameter int DATA_W = 32,
  parameter int OP_W = 4
);
  logic iStart;
  logic [OP_W-1:0] iOp;
  logic [DATA_W-1:0] iA, iB, oHI, oLO;
  logic oBusy, oDone, oDivZero;
  modport master(output iStart, iOp, iA, iB, input oBusy, oDone, oDivZero, oHI, oLO);
  modport slave(input iStart, iOp, iA, iB, output oBusy, oDone, oDivZero, oHI, oLO);
endinterface

// File: rtl/md_divider.sv
// md_divider: unsigned restoring divider, one quotient bit per cycle; start_i loads dvd_i/dvs_i, done_o marks the final iteration edge, quo_o/rem_o hold the result
module md_divider #(
  parameter int W = 32
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic start_i,
  input  logic [W-1:0] dvd_i,
  input  logic [W-1:0] dvs_i,
  output logic done_o,
  output logic [W-1:0] quo_o,
  output logic [W-1:0] rem_o
);
  localparam int CW = $clog2(W + 1);
  logic [W-1:0] quo_q, rem_q, dvs_q;
  logic [CW-1:0] cnt_q;
  logic [W:0] trial;
  assign trial = {rem_q, quo_q[W-1]} - {1'b0, dvs_q};
  assign done_o = cnt_q == CW'(1);
  assign quo_o = quo_q;
  assign rem_o = rem_q;
  always_ff @(posedge iCLK)
    if (iRST) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      quo_q <= dvd_i;
      rem_q <= '0;
      dvs_q <= dvs_i;
      cnt_q <= CW'(W);
    end else if (cnt_q != '0) begin
      rem_q <= trial[W] ? {rem_q[W-2:0], quo_q[W-1]} : trial[W-1:0];
      quo_q <= {quo_q[W-2:0], !trial[W]};
      cnt_q <= cnt_q - 1'b1;
    end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: HI/LO owner with multi-cycle multiply/MAC and iterative divide; ports iCLK, iRST, md (slave: iStart/iOp/iA/iB in, oBusy/oDone/oDivZero/oHI/oLO out)
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int MUL_LAT = 2,
  parameter int OP_W = 4
) (
  input logic iCLK,
  input logic iRST,
  mult_div_unit_if.slave md
);
  localparam int W = DATA_W;
  localparam int CW = $clog2(MUL_LAT + 1);
  state_t st_q, st_d;
  logic [W-1:0] hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d, mag_a, mag_b, quo, rem;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sgn_q, sgn_d, add_q, add_d, sub_q, sub_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic done_q, done_d, dz_q, dz_d, is_mul, is_div, is_sgn, div_start, div_done;
  logic [2*W-1:0] prod, acc;
  assign is_mul = md.iOp inside {OP_W'(MD_MULT), OP_W'(MD_MULTU), OP_W'(MD_MADD), OP_W'(MD_MADDU), OP_W'(MD_MSUB), OP_W'(MD_MSUBU)};
  assign is_div = md.iOp inside {OP_W'(MD_DIV), OP_W'(MD_DIVU)};
  assign is_sgn = md.iOp inside {OP_W'(MD_MULT), OP_W'(MD_DIV), OP_W'(MD_MADD), OP_W'(MD_MSUB)};
  assign mag_a = is_sgn && md.iA[W-1] ? -md.iA : md.iA;
  assign mag_b = is_sgn && md.iB[W-1] ? -md.iB : md.iB;
  assign prod = (sgn_q ? {{W{a_q[W-1]}}, a_q} : {{W{1'b0}}, a_q}) * (sgn_q ? {{W{b_q[W-1]}}, b_q} : {{W{1'b0}}, b_q});
  // MAC reads HI/LO at the write edge, so an intervening MTHI/MTLO cannot be lost
  assign acc = {hi_q, lo_q};
  md_divider #(.W(W)) u_div (
    .iCLK(iCLK), .iRST(iRST), .start_i(div_start), .dvd_i(mag_a), .dvs_i(mag_b),
    .done_o(div_done), .quo_o(quo), .rem_o(rem)
  );
  always_comb begin
    st_d = st_q;
    hi_d = hi_q;
    lo_d = lo_q;
    a_d = a_q;
    b_d = b_q;
    cnt_d = cnt_q;
    sgn_d = sgn_q;
    add_d = add_q;
    sub_d = sub_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    dz_d = dz_q;
    done_d = 1'b0;
    div_start = 1'b0;
    if (st_q == IDLE && md.iStart) begin
      done_d = !is_mul && !(is_div && md.iB != '0);
      if (is_mul) begin
        st_d = MUL;
        a_d = md.iA;
        b_d = md.iB;
        sgn_d = is_sgn;
        add_d = md.iOp inside {OP_W'(MD_MADD), OP_W'(MD_MADDU)};
        sub_d = md.iOp inside {OP_W'(MD_MSUB), OP_W'(MD_MSUBU)};
        cnt_d = CW'(MUL_LAT - 1);
      end else if (is_div && md.iB == '0)
        dz_d = 1'b1;
      else if (is_div) begin
        st_d = DIV;
        dz_d = 1'b0;
        div_start = 1'b1;
        qneg_d = is_sgn && (md.iA[W-1] ^ md.iB[W-1]);
        rneg_d = is_sgn && md.iA[W-1];
      end else if (md.iOp == OP_W'(MD_MTHI))
        hi_d = md.iA;
      else if (md.iOp == OP_W'(MD_MTLO))
        lo_d = md.iA;
    end else if (st_q == MUL) begin
      if (cnt_q == '0) begin
        {hi_d, lo_d} = add_q ? acc + prod : sub_q ? acc - prod : prod;
        st_d = IDLE;
        done_d = 1'b1;
      end else
        cnt_d = cnt_q - 1'b1;
    end else if (st_q == DIV)
      st_d = div_done ? FIX : DIV;
    else if (st_q == FIX) begin
      lo_d = qneg_q ? -quo : quo;
      hi_d = rneg_q ? -rem : rem;
      st_d = IDLE;
      done_d = 1'b1;
    end
  end
  always_ff @(posedge iCLK)
    if (iRST) begin
      st_q <= IDLE;
      hi_q <= '0;
      lo_q <= '0;
      a_q <= '0;
      b_q <= '0;
      cnt_q <= '0;
      sgn_q <= 1'b0;
      add_q <= 1'b0;
      sub_q <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q <= st_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      a_q <= a_d;
      b_q <= b_d;
      cnt_q <= cnt_d;
      sgn_q <= sgn_d;
      add_q <= add_d;
      sub_q <= sub_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      dz_q <= dz_d;
      done_q <= done_d;
    end
  assign md.oBusy = st_q != IDLE;
  assign md.oDone = done_q;
  assign md.oDivZero = dz_q;
  assign md.oHI = hi_q;
  assign md.oLO = lo_q;
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised multi-cycle multiply/divide unit owning the HI/LO register pair for the MIPS core.
- Replaces single-cycle HI/LO arithmetic: pipelined multiply, iterative restoring divide, multiply-accumulate.
- Busy/done handshake lets the control unit stall on mfhi/mflo hazards.
- Sits beside the ALU in the execute stage; oHI/oLO feed the mfhi/mflo result mux.

Parameters:
- DATA_W, 32: operand width; HI and LO are each DATA_W bits.
- MUL_LAT, 2: multiply/MAC latency in cycles from acceptance to done, >=1.
- OP_W, 4: width of iOp.

Ports:
- iCLK  in  1  clock, rising edge.
- iRST  in  1  reset, synchronous, active-high.
- iStart  in  1  request; accepted when iStart && !oBusy.
- iOp  in  OP_W  operation code, sampled at acceptance.
- iA  in  DATA_W  operand A (rs), sampled at acceptance.
- iB  in  DATA_W  operand B (rt), sampled at acceptance.
- oBusy  out  1  operation in progress; new requests ignored.
- oDone  out  1  one-cycle pulse: HI/LO now hold the result.
- oDivZero  out  1  sticky-per-op flag: last divide had iB==0.
- oHI  out  DATA_W  HI register.
- oLO  out  DATA_W  LO register.

Behaviour:
- Reset: the unit is reset by iRST, synchronous, active-high; clock iCLK.
  - During reset: HI=LO=0, oBusy=0, oDone=0, oDivZero=0, FSM=IDLE.
  - Reset mid-operation aborts the operation; HI/LO are cleared.
- Ops: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO.
  - Any other code: accepted as a no-op, oDone pulses next cycle, HI/LO unchanged.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE->MUL on mult/MAC acceptance.
  - IDLE->DIV on divide acceptance with iB!=0.
  - MUL->IDLE after MUL_LAT cycles.
  - DIV->FIX after DATA_W iterations.
  - FIX->IDLE after 1 cycle.
- Timing: acceptance edge is E0.
  - oBusy is high from E0 until the edge at which the result is written.
  - oDone is high in the cycle after that write.
  - oBusy is low in the oDone cycle, so back-to-back issue is allowed there.
  - Mult/MAC: result written at E0+MUL_LAT.
  - Divide: result written at E0+DATA_W+1.
  - MTHI/MTLO: HI<=iA or LO<=iA at E0; never busy; oDone at E0+1.
- Multiply arithmetic:
  - Signed ops use a 2*DATA_W signed product; unsigned ops zero-extend the operands.
  - {HI,LO} <= product.
  - MADD: {HI,LO} + product. MSUB: {HI,LO} - product. Both wrap modulo 2^(2*DATA_W).
  - The accumulator value is read at the write edge, not at acceptance.
- Divide arithmetic:
  - Operands are converted to magnitudes at acceptance.
  - Restoring divide runs one quotient bit per cycle.
  - FIX applies signs: quotient truncates toward zero; remainder takes the dividend's sign.
  - LO=quotient, HI=remainder.
  - MIN/-1 gives LO=MIN, HI=0.
- Divide by zero (iB==0):
  - No DIV state is entered; HI/LO are unchanged.
  - oDivZero=1 and oDone pulses at E0+1.
  - oDivZero clears on the next accepted divide with nonzero iB, or on reset.
- iStart while oBusy: ignored, no queuing. Operand changes during busy have no effect.
- Outputs: oHI/oLO are registered and change only at write edges or reset.

Decomposition:
- Shared package: op-code localparams (MD_MULT..MD_MTLO) and FSM state encoding.
  - ALUOP-style shared constants remain the source for the decoder mapping.
- One natural sub-module: md_divider.
  - Iterative unsigned restoring divider: start/done handshake, magnitude in, quotient/remainder out.
  - mult_div_unit handles sign pre- and post-processing, the multiply pipeline and HI/LO.

Test Plan:
- Signed multiply: MULT A=-3 (0xFFFFFFFD), B=7, MUL_LAT=2.
  - Response: oDone at E0+3 cycle; HI=0xFFFFFFFF, LO=0xFFFFFFEB; oBusy high 2 cycles.
- Unsigned multiply: MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- Signed divide: DIV A=-7, B=2.
  - Response: LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); oDone exactly DATA_W+2 cycles after E0.
- Overflow divide: DIV A=0x80000000, B=-1 -> LO=0x80000000, HI=0.
- Divide by zero: MTHI 0x11, MTLO 0x22, then DIVU B=0.
  - Response: HI=0x11, LO=0x22 unchanged; oDivZero=1; oDone next cycle.
- Accumulate, busy and reset handling:
  - MTHI 0, MTLO 10, then MADD A=3, B=4 -> LO=22. Then MSUBU A=5, B=5 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - iStart during busy is ignored.
  - iRST asserted mid-DIV -> HI=LO=0, oBusy=0, no oDone.
